// File: rtl/ord_sram_pkg.sv
// Shared types for the ord_sram arbiter: FSM states and the per-requester
// request bundle that is muxed onto the single SRAM port.
package ord_sram_pkg;

  localparam int NUM_REQ_MAX = 4;

  // Request lanes are sized for the default SRAM geometry; the top's width
  // parameters must not exceed these.
  localparam int SRAM_ADDR_W = 16;
  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_BE_W   = SRAM_DATA_W / 8;
  localparam int SRAM_VLEN   = 32;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [SRAM_BE_W-1:0]   be;
    logic [SRAM_VLEN-1:0]   pc;
    logic [SRAM_ADDR_W-1:0] addr_t0;
    logic [SRAM_DATA_W-1:0] wdata_t0;
  } arb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping, reported as a one-hot grant plus the winner's index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((int'(ptr_i) + off) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/ord_sram_arb.sv
// Shares one single-port SRAM between NUM_REQ requesters: zero-init sweep
// after reset, then round-robin arbitration with read-data steering and taint.
module ord_sram_arb
  import ord_sram_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int ADDR_W     = SRAM_ADDR_W,
  parameter  int DATA_W     = SRAM_DATA_W,
  parameter  int INIT_WORDS = 32,
  parameter  int VLEN       = SRAM_VLEN,
  localparam int NUM_BYTES  = DATA_W / 8,
  localparam int PTR_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     wdata_i,
  input  logic [NUM_REQ*NUM_BYTES-1:0]  be_i,
  input  logic [NUM_REQ*VLEN-1:0]       pc_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     addr_t0_i,
  input  logic [NUM_REQ*DATA_W-1:0]     wdata_t0_i,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [DATA_W-1:0]             rdata_t0_o,
  output logic                          init_done_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [ADDR_W-1:0]             sram_addr_o,
  output logic [DATA_W-1:0]             sram_wdata_o,
  output logic [NUM_BYTES-1:0]          sram_be_o,
  output logic [VLEN-1:0]               sram_pc_o,
  output logic [ADDR_W-1:0]             sram_addr_t0_o,
  output logic [DATA_W-1:0]             sram_wdata_t0_o,
  input  logic [DATA_W-1:0]             sram_rdata_i,
  input  logic [DATA_W-1:0]             sram_rdata_t0_i
);

  state_e           state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic             rd_pend_q;
  logic [PTR_W-1:0] rd_owner_q;
  logic             init_done_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   win_idx;
  logic               win_valid;
  logic               grant;
  arb_req_t           cand [NUM_REQ];
  arb_req_t           win;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i].we       = we_i[i];
      cand[i].addr     = SRAM_ADDR_W'(addr_i[i*ADDR_W +: ADDR_W]);
      cand[i].wdata    = SRAM_DATA_W'(wdata_i[i*DATA_W +: DATA_W]);
      cand[i].be       = SRAM_BE_W'(be_i[i*NUM_BYTES +: NUM_BYTES]);
      cand[i].pc       = SRAM_VLEN'(pc_i[i*VLEN +: VLEN]);
      cand[i].addr_t0  = SRAM_ADDR_W'(addr_t0_i[i*ADDR_W +: ADDR_W]);
      cand[i].wdata_t0 = SRAM_DATA_W'(wdata_t0_i[i*DATA_W +: DATA_W]);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign win      = cand[win_idx];
  assign grant    = !rst_i && (state_q == RUN) && win_valid;
  assign rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Every output is forced to zero while rst_i is high, including a response
  // that would otherwise land in the reset cycle.
  always_comb begin
    gnt_o           = '0;
    sram_req_o      = 1'b0;
    sram_we_o       = 1'b0;
    sram_addr_o     = '0;
    sram_wdata_o    = '0;
    sram_be_o       = '0;
    sram_pc_o       = '0;
    sram_addr_t0_o  = '0;
    sram_wdata_t0_o = '0;
    rvalid_o        = '0;
    rdata_o         = '0;
    rdata_t0_o      = '0;
    if (!rst_i && (state_q == INIT)) begin
      sram_req_o  = 1'b1;
      sram_we_o   = 1'b1;
      sram_be_o   = '1;
      sram_addr_o = init_cnt_q;
    end else if (grant) begin
      gnt_o           = arb_gnt;
      sram_req_o      = 1'b1;
      sram_we_o       = win.we;
      sram_addr_o     = ADDR_W'(win.addr);
      sram_wdata_o    = DATA_W'(win.wdata);
      sram_be_o       = NUM_BYTES'(win.be);
      sram_pc_o       = VLEN'(win.pc);
      sram_addr_t0_o  = ADDR_W'(win.addr_t0);
      sram_wdata_t0_o = DATA_W'(win.wdata_t0);
    end
    if (!rst_i && rd_pend_q) begin
      rvalid_o[rd_owner_q] = 1'b1;
      rdata_o              = sram_rdata_i;
      rdata_t0_o           = sram_rdata_t0_i;
    end
  end

  assign init_done_o = init_done_q & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          rd_pend_q  <= 1'b0;
          if (init_cnt_q == ADDR_W'(INIT_WORDS - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          rd_pend_q <= grant && !win.we;
          if (grant) begin
            rr_ptr_q   <= rr_ptr_d;
            rd_owner_q <= win_idx;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ord_sram_arb.sv
// Self-checking bench for ord_sram_arb: behavioural SRAM with byte-lane taint,
// reference model of the init sweep, round-robin grants and read returns.
module tb_ord_sram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [31:0] addr, addr_t0;
  logic [127:0] wdata, wdata_t0;
  logic [15:0] be;
  logic [63:0] pc;
  logic [1:0]  gnt, rvalid;
  logic [63:0] rdata, rdata_t0;
  logic        init_done;
  logic        sram_req, sram_we;
  logic [15:0] sram_addr, sram_addr_t0;
  logic [63:0] sram_wdata, sram_wdata_t0;
  logic [7:0]  sram_be;
  logic [31:0] sram_pc;
  logic [63:0] sram_rdata, sram_rdata_t0;

  always #5 clk = ~clk;

  ord_sram_arb dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .pc_i(pc),
    .addr_t0_i(addr_t0), .wdata_t0_i(wdata_t0),
    .rvalid_o(rvalid), .rdata_o(rdata), .rdata_t0_o(rdata_t0),
    .init_done_o(init_done),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_pc_o(sram_pc),
    .sram_addr_t0_o(sram_addr_t0), .sram_wdata_t0_o(sram_wdata_t0),
    .sram_rdata_i(sram_rdata), .sram_rdata_t0_i(sram_rdata_t0)
  );

  // SRAM environment: 1-cycle read latency, byte-enabled data and taint writes;
  // reset fills it with non-zero junk so the zero sweep is observable.
  logic [63:0] sramMem [0:63];
  logic [63:0] sramT0  [0:63];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        sramMem[i] <= 64'hA5A5_A5A5_0000_0000 | 64'(i);
        sramT0[i]  <= 64'hFFFF_0000_FFFF_0000;
      end
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++) begin
          if (sram_be[b]) begin
            sramMem[sram_addr[5:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            sramT0[sram_addr[5:0]][b*8 +: 8]  <= sram_wdata_t0[b*8 +: 8];
          end
        end
      end else begin
        sram_rdata    <= sramMem[sram_addr[5:0]];
        sram_rdata_t0 <= sramT0[sram_addr[5:0]];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Stimulus for the current cycle, one entry per requester
  logic [1:0]  tReq, tWe;
  logic [15:0] tAddr [2];
  logic [15:0] tAddrT0 [2];
  logic [63:0] tWdata [2];
  logic [63:0] tWdataT0 [2];
  logic [7:0]  tBe [2];
  logic [31:0] tPc [2];

  // Reference model state
  logic [63:0] refMem [0:31];
  logic [63:0] refT0  [0:31];
  int          rrPtr;
  bit          pendValid;
  int          pendOwner;
  logic [63:0] pendData, pendT0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs();
    req      = tReq;
    we       = tWe;
    addr     = {tAddr[1], tAddr[0]};
    addr_t0  = {tAddrT0[1], tAddrT0[0]};
    wdata    = {tWdata[1], tWdata[0]};
    wdata_t0 = {tWdataT0[1], tWdataT0[0]};
    be       = {tBe[1], tBe[0]};
    pc       = {tPc[1], tPc[0]};
  endtask

  task automatic setReq(input int k, input bit w, input logic [15:0] a, input logic [63:0] d,
                        input logic [7:0] b, input logic [63:0] dt0);
    tReq[k]     = 1'b1;
    tWe[k]      = w;
    tAddr[k]    = a;
    tWdata[k]   = d;
    tBe[k]      = b;
    tWdataT0[k] = dt0;
    tAddrT0[k]  = 16'(k + 1);
    tPc[k]      = $urandom;
  endtask

  // Asserts reset for n cycles, checking outputs are silent throughout.
  task automatic doReset(input int n);
    rst  = 1'b1;
    tReq = 2'b11;
    driveInputs();
    #1;
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_sram_req", 64'(sram_req), 64'd0);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      checkOutput("rst_gnt", 64'(gnt), 64'd0);
      checkOutput("rst_sram_req", 64'(sram_req), 64'd0);
      checkOutput("rst_init_done", 64'(init_done), 64'd0);
      checkOutput("rst_rdata", rdata, 64'd0);
    end
    rst = 1'b0;
  endtask

  // Zero sweep of words 0..31 while both requesters ask; no grant allowed.
  task automatic runInitSweep();
    for (int i = 0; i < 32; i++) begin
      tReq = 2'b11;
      driveInputs();
      #1;
      checkOutput("init_req", 64'(sram_req), 64'd1);
      checkOutput("init_we", 64'(sram_we), 64'd1);
      checkOutput("init_addr", 64'(sram_addr), 64'(i));
      checkOutput("init_wdata", sram_wdata | sram_wdata_t0, 64'd0);
      checkOutput("init_be", 64'(sram_be), 64'hFF);
      checkOutput("init_gnt", 64'(gnt), 64'd0);
      checkOutput("init_done_early", 64'(init_done), 64'd0);
      @(posedge clk); #1;
    end
    checkOutput("init_done", 64'(init_done), 64'd1);
    for (int i = 0; i < 32; i++) begin
      refMem[i] = 64'd0;
      refT0[i]  = 64'd0;
    end
    rrPtr     = 0;
    pendValid = 1'b0;
  endtask

  // One RUN cycle: drive tReq/fields, compare against the model, advance.
  task automatic applyStimulus();
    int          winner;
    logic [1:0]  expGnt, expRvalid;
    logic [63:0] merged, mergedT0;
    driveInputs();
    #1;
    winner = -1;
    if (tReq[rrPtr]) winner = rrPtr;
    else if (tReq[1 - rrPtr]) winner = 1 - rrPtr;
    expGnt    = (winner < 0) ? 2'b00 : 2'(1 << winner);
    expRvalid = pendValid ? 2'(1 << pendOwner) : 2'b00;
    checkOutput("gnt", 64'(gnt), 64'(expGnt));
    checkOutput("rvalid", 64'(rvalid), 64'(expRvalid));
    checkOutput("rdata", rdata, pendValid ? pendData : 64'd0);
    checkOutput("rdata_t0", rdata_t0, pendValid ? pendT0 : 64'd0);
    checkOutput("sram_req", 64'(sram_req), (winner < 0) ? 64'd0 : 64'd1);
    if (winner >= 0) begin
      checkOutput("sram_we", 64'(sram_we), 64'(tWe[winner]));
      checkOutput("sram_addr", 64'(sram_addr), 64'(tAddr[winner]));
      checkOutput("sram_addr_t0", 64'(sram_addr_t0), 64'(tAddrT0[winner]));
      checkOutput("sram_pc", 64'(sram_pc), 64'(tPc[winner]));
      if (tWe[winner]) begin
        checkOutput("sram_wdata", sram_wdata, tWdata[winner]);
        checkOutput("sram_wdata_t0", sram_wdata_t0, tWdataT0[winner]);
        checkOutput("sram_be", 64'(sram_be), 64'(tBe[winner]));
      end
    end else begin
      checkOutput("idle_addr", 64'(sram_addr), 64'd0);
    end
    pendValid = 1'b0;
    if (winner >= 0) begin
      rrPtr = (winner + 1) % 2;
      if (tWe[winner]) begin
        merged   = refMem[tAddr[winner][4:0]];
        mergedT0 = refT0[tAddr[winner][4:0]];
        for (int b = 0; b < 8; b++) begin
          if (tBe[winner][b]) begin
            merged[b*8 +: 8]   = tWdata[winner][b*8 +: 8];
            mergedT0[b*8 +: 8] = tWdataT0[winner][b*8 +: 8];
          end
        end
        refMem[tAddr[winner][4:0]] = merged;
        refT0[tAddr[winner][4:0]]  = mergedT0;
      end else begin
        pendValid = 1'b1;
        pendOwner = winner;
        pendData  = refMem[tAddr[winner][4:0]];
        pendT0    = refT0[tAddr[winner][4:0]];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clearReqs();
    tReq = 2'b00;
    tWe  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      tAddr[k] = '0; tAddrT0[k] = '0; tWdata[k] = '0;
      tWdataT0[k] = '0; tBe[k] = '0; tPc[k] = '0;
    end
  endtask

  initial begin
    clearReqs();
    pendValid = 1'b0;
    rrPtr     = 0;
    doReset(3);
    runInitSweep();

    // Single read from requester 0 of a freshly zeroed word
    clearReqs(); setReq(0, 1'b0, 16'd5, 64'd0, 8'h00, 64'd0);
    applyStimulus();
    checkOutput("rd5_rvalid_lit", 64'(rvalid), 64'h1);
    checkOutput("rd5_rdata_lit", rdata, 64'd0);
    clearReqs(); applyStimulus();

    // Both requesters read every cycle: grants must alternate
    for (int c = 0; c < 6; c++) begin
      clearReqs();
      setReq(0, 1'b0, 16'd1, 64'd0, 8'h00, 64'd0);
      setReq(1, 1'b0, 16'd2, 64'd0, 8'h00, 64'd0);
      applyStimulus();
    end
    clearReqs(); applyStimulus();

    // Partial-byte write followed immediately by a read of the same word
    clearReqs(); setReq(1, 1'b1, 16'd3, 64'hDEADBEEF_CAFEF00D, 8'h0F, 64'd0);
    applyStimulus();
    clearReqs(); setReq(1, 1'b0, 16'd3, 64'd0, 8'h00, 64'd0);
    applyStimulus();
    checkOutput("be_merge_lit", rdata, 64'h00000000_CAFEF00D);
    clearReqs(); applyStimulus();

    // Tainted write data comes back on the read taint bus
    clearReqs(); setReq(0, 1'b1, 16'd7, 64'h1234, 8'hFF, 64'hFF);
    applyStimulus();
    clearReqs(); setReq(0, 1'b0, 16'd7, 64'd0, 8'h00, 64'd0);
    applyStimulus();
    checkOutput("taint_lit", rdata_t0, 64'h0000_0000_0000_00FF);
    clearReqs(); applyStimulus();

    // Reset the cycle after a read grant: response dropped, sweep restarts
    clearReqs(); setReq(0, 1'b0, 16'd3, 64'd0, 8'h00, 64'd0);
    applyStimulus();
    doReset(1);
    runInitSweep();

    // Randomised traffic over the zeroed region
    for (int c = 0; c < 400; c++) begin
      clearReqs();
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          setReq(k, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'd0);
        end
      end
      applyStimulus();
    end
    clearReqs(); applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
